// File: rtl/gmii_pkg.sv
// Shared constants, state type and CRC32 helper for the GMII frame generator
// and the matching receive checker.
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned MIN_PAYLOAD   = 46;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [3:0] {
        StIdle,
        StPreamble,
        StSfd,
        StDst,
        StSrc,
        StLen,
        StPayload,
        StPad,
        StFcs,
        StIfg
    } gen_state_t;

    // Reflected CRC32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte k of a MAC address, most significant byte first.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC32 register: synchronous init, accumulate when en is high.
// crc_next exposes the value including the current data byte.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic [31:0] crc_next
);

    logic [31:0] crc_q;

    assign crc_next = crc32_byte(crc_q, data);
    assign crc      = crc_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII test-frame generator: bursts of identical Ethernet II frames with
// patterned payload, padding, FCS and optional CRC / tx_er fault injection.
module gmii_frame_gen
    import gmii_pkg::*;
#(
    parameter logic [47:0]  DEST_MAC  = 48'h023528fbdd66,
    parameter logic [47:0]  SRC_MAC   = 48'h072227acdb65,
    parameter int unsigned  MAX_LEN   = 1500,
    parameter int unsigned  IFG_BYTES = 12,
    parameter int unsigned  CNT_W     = 16,
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       seed,
    input  logic [CNT_W-1:0] num_frames,
    input  logic             crc_corrupt,
    input  logic             er_inject,
    output logic [7:0]       gmii_tx_d,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    gen_state_t       state_q;
    logic [15:0]      cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       seed_q;
    logic [CNT_W-1:0] num_q;
    logic             corrupt_q;
    logic             er_q;
    logic             stop_pend_q;
    logic [7:0]       d_q;
    logic             en_q;
    logic             er_out_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] sent_q;

    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [LEN_W-1:0] len_clamp;
    logic [15:0]      len_field;
    logic             pay_last;
    logic             pad_needed;
    logic             end_cond;
    logic [7:0]       fcs_first;
    logic [7:0]       fcs_hi;

    // The byte on the wire is folded into the CRC one cycle later, so the
    // first FCS byte has to come from crc_next rather than the register.
    crc32_d8 u_crc (
        .clk      (clk),
        .rst      (rst),
        .init     (state_q == StPreamble),
        .en       (state_q inside {StDst, StSrc, StLen, StPayload, StPad}),
        .data     (d_q),
        .crc      (crc),
        .crc_next (crc_next)
    );

    always_comb begin
        len_clamp = len;
        if (32'(len) > MAX_LEN) begin
            len_clamp = LEN_W'(MAX_LEN);
        end
        len_field  = 16'(len_q);
        pay_last   = (cnt_q == len_field - 16'd1);
        pad_needed = (len_field < 16'(MIN_PAYLOAD));
        end_cond   = ((num_q != '0) && (sent_q == num_q)) || stop_pend_q || stop;
        fcs_first  = ~crc_next[7:0] ^ {7'b0, corrupt_q};
        case (cnt_q[1:0])
            2'd0:    fcs_hi = ~crc[15:8];
            2'd1:    fcs_hi = ~crc[23:16];
            default: fcs_hi = ~crc[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            num_q       <= '0;
            corrupt_q   <= 1'b0;
            er_q        <= 1'b0;
            stop_pend_q <= 1'b0;
            d_q         <= '0;
            en_q        <= 1'b0;
            er_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sent_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            er_out_q <= 1'b0;
            if (state_q != StIdle && stop) begin
                stop_pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    stop_pend_q <= 1'b0;
                    if (start) begin
                        len_q     <= len_clamp;
                        seed_q    <= seed;
                        num_q     <= num_frames;
                        corrupt_q <= crc_corrupt;
                        er_q      <= er_inject;
                        sent_q    <= '0;
                        state_q   <= StPreamble;
                        cnt_q     <= '0;
                        d_q       <= PREAMBLE_BYTE;
                        en_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StPreamble: begin
                    if (cnt_q == 16'd6) begin
                        state_q <= StSfd;
                        d_q     <= SFD_BYTE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StSfd: begin
                    state_q <= StDst;
                    cnt_q   <= '0;
                    d_q     <= mac_byte(DEST_MAC, 3'd0);
                end
                StDst: begin
                    if (cnt_q == 16'd5) begin
                        state_q <= StSrc;
                        cnt_q   <= '0;
                        d_q     <= mac_byte(SRC_MAC, 3'd0);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        d_q   <= mac_byte(DEST_MAC, cnt_q[2:0] + 3'd1);
                    end
                end
                StSrc: begin
                    if (cnt_q == 16'd5) begin
                        state_q <= StLen;
                        cnt_q   <= '0;
                        d_q     <= len_field[15:8];
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        d_q   <= mac_byte(SRC_MAC, cnt_q[2:0] + 3'd1);
                    end
                end
                StLen: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= 16'd1;
                        d_q   <= len_field[7:0];
                    end else if (len_field == 16'd0) begin
                        state_q <= StPad;
                        cnt_q   <= '0;
                        d_q     <= 8'h00;
                    end else begin
                        state_q  <= StPayload;
                        cnt_q    <= '0;
                        d_q      <= seed_q;
                        er_out_q <= er_q;
                    end
                end
                StPayload: begin
                    if (pay_last && pad_needed) begin
                        state_q <= StPad;
                        cnt_q   <= cnt_q + 16'd1;
                        d_q     <= 8'h00;
                    end else if (pay_last) begin
                        state_q <= StFcs;
                        cnt_q   <= '0;
                        d_q     <= fcs_first;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        d_q   <= seed_q + cnt_q[7:0] + 8'd1;
                    end
                end
                StPad: begin
                    // cnt_q keeps counting payload positions so padding ends at 46 bytes.
                    if (cnt_q == 16'(MIN_PAYLOAD - 1)) begin
                        state_q <= StFcs;
                        cnt_q   <= '0;
                        d_q     <= fcs_first;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        d_q   <= 8'h00;
                    end
                end
                StFcs: begin
                    if (cnt_q == 16'd3) begin
                        state_q <= StIfg;
                        cnt_q   <= '0;
                        d_q     <= 8'h00;
                        en_q    <= 1'b0;
                        if (IFG_BYTES == 1) begin
                            done_q <= end_cond;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        d_q   <= fcs_hi;
                        if (cnt_q == 16'd2 && sent_q != '1) begin
                            sent_q <= sent_q + CNT_W'(1);
                        end
                    end
                end
                StIfg: begin
                    // done_q is raised only for the last gap cycle of the burst.
                    if (cnt_q == 16'(IFG_BYTES - 1)) begin
                        cnt_q <= '0;
                        if (done_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StPreamble;
                            d_q     <= PREAMBLE_BYTE;
                            en_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (32'(cnt_q) + 32'd2 == IFG_BYTES) begin
                            done_q <= end_cond;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gmii_tx_d   = d_q;
    assign gmii_tx_en  = en_q;
    assign gmii_tx_er  = er_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = sent_q;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Self-checking bench for gmii_frame_gen: directed and random bursts compared
// byte-for-byte against a frame model built from the Ethernet framing rules.
module tb_gmii_frame_gen;

    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [10:0] len = '0;
    logic [7:0]  seed = '0;
    logic [15:0] num_frames = '0;
    logic        crc_corrupt = 1'b0;
    logic        er_inject = 1'b0;
    logic [7:0]  gmii_tx_d;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    gmii_frame_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .len         (len),
        .seed        (seed),
        .num_frames  (num_frames),
        .crc_corrupt (crc_corrupt),
        .er_inject   (er_inject),
        .gmii_tx_d   (gmii_tx_d),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial reflected CRC32 register (uncomplemented) over q[from..end].
    function automatic logic [31:0] crc_reg(input logic [7:0] q[$], input int from);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = from; i < q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic build_frame(input int l, input logic [7:0] s, input bit corrupt);
        int          nl;
        logic [47:0] dm;
        logic [47:0] sm;
        logic [15:0] lf;
        logic [31:0] fcs;
        nl = (l > 1500) ? 1500 : l;
        dm = 48'h023528fbdd66;
        sm = 48'h072227acdb65;
        lf = 16'(nl);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(dm[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(sm[47-8*i -: 8]);
        exp_q.push_back(lf[15:8]);
        exp_q.push_back(lf[7:0]);
        for (int i = 0; i < nl; i++) exp_q.push_back(8'(s + 8'(i)));
        for (int i = nl; i < 46; i++) exp_q.push_back(8'h00);
        fcs = ~crc_reg(exp_q, 8);
        exp_q.push_back(fcs[7:0] ^ {7'b0, corrupt});
        exp_q.push_back(fcs[15:8]);
        exp_q.push_back(fcs[23:16]);
        exp_q.push_back(fcs[31:24]);
    endtask

    // stop_frame > 0 pulses stop while frame number stop_frame is on the wire.
    task automatic run_burst(input int l, input logic [7:0] s, input int nf, input bit corrupt,
                             input bit er, input int stop_frame, input bit stop_with_start,
                             input int exp_frames);
        int          frames, gap, done_cnt, done_gap, idle_bad, er_cnt, er_pos, mism;
        bit          in_frame;
        logic [31:0] c, r;
        build_frame(l, s, corrupt);
        frames = 0; gap = 0; done_cnt = 0; done_gap = -1; idle_bad = 0;
        er_cnt = 0; er_pos = -1; in_frame = 0;
        @(posedge clk); #1;
        start = 1'b1; stop = stop_with_start; len = 11'(l); seed = s;
        num_frames = 16'(nf); crc_corrupt = corrupt; er_inject = er;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        // Scramble the configuration inputs to show they were latched.
        len = 11'($urandom); seed = 8'($urandom); num_frames = 16'($urandom);
        crc_corrupt = 1'($urandom); er_inject = 1'($urandom);
        @(negedge clk);
        check("first_preamble", {gmii_tx_en, gmii_tx_d}, {1'b1, 8'h55});
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!busy) break;
            if (gmii_tx_en) begin
                if (!in_frame) begin
                    in_frame = 1;
                    got_q.delete();
                    er_cnt = 0;
                    er_pos = -1;
                    if (frames > 0) check("ifg_len", gap, IFG);
                end
                if (gmii_tx_er) begin
                    er_cnt++;
                    er_pos = got_q.size();
                end
                got_q.push_back(gmii_tx_d);
                stop = (stop_frame == frames + 1) && (got_q.size() == 30);
            end else begin
                stop = 1'b0;
                if (in_frame) begin
                    in_frame = 0;
                    frames++;
                    gap = 0;
                    check("frame_len", got_q.size(), exp_q.size());
                    mism = 0;
                    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                        if (got_q[i] !== exp_q[i]) mism++;
                    end
                    check("frame_bytes_wrong", mism, 0);
                    c = crc_reg(got_q, 8);
                    r = {<<{c}};
                    if (corrupt) check("residue_is_good", r == 32'hC704DD7B, 0);
                    else check("residue", r, 32'hC704DD7B);
                    check("er_count", er_cnt, er);
                    if (er) check("er_pos", er_pos, 22);
                    check("frames_sent_step", frames_sent, frames);
                end
                gap++;
                if (gmii_tx_d != 8'h00 || gmii_tx_er) idle_bad++;
            end
            if (done) begin
                done_cnt++;
                done_gap = gap;
            end
        end
        stop = 1'b0;
        check("burst_ended", busy, 0);
        check("frames", frames, exp_frames);
        check("frames_sent_final", frames_sent, exp_frames);
        check("done_pulses", done_cnt, 1);
        check("done_at_gap", done_gap, IFG);
        check("final_gap", gap, IFG);
        check("idle_data_nonzero", idle_bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {gmii_tx_d, gmii_tx_en, gmii_tx_er, busy, done, frames_sent}, '0);
        rst = 1'b0;

        run_burst(46, 8'h00, 1, 0, 0, 0, 0, 1);
        run_burst(10, 8'hF8, 1, 0, 0, 0, 0, 1);
        run_burst(2000, 8'($urandom), 1, 0, 0, 0, 0, 1);
        run_burst(60, 8'h33, 3, 0, 0, 0, 0, 3);
        run_burst(50, 8'h80, 0, 0, 0, 2, 0, 2);
        run_burst(20, 8'hA5, 2, 1, 1, 0, 0, 2);
        run_burst(0, 8'h11, 1, 0, 0, 0, 0, 1);

        // stop in IDLE is dropped; stop together with start loses to start.
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        run_burst(47, 8'h5A, 2, 0, 0, 0, 0, 2);
        run_burst(45, 8'hC3, 2, 0, 0, 0, 1, 2);

        for (int k = 0; k < 5; k++) begin
            int l, nf;
            l  = $urandom_range(0, 1600);
            nf = $urandom_range(1, 2);
            run_burst(l, 8'($urandom), nf, 1'($urandom), 1'($urandom), 0, 0, nf);
        end

        // Reset during payload of a continuous burst.
        @(posedge clk); #1;
        start = 1'b1; len = 11'd100; seed = 8'h01; num_frames = 16'd0;
        crc_corrupt = 1'b0; er_inject = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_payload_busy", {busy, gmii_tx_en}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_frame", {gmii_tx_d, gmii_tx_en, gmii_tx_er, busy, done, frames_sent}, '0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {busy, gmii_tx_en}, 2'b00);
        run_burst(46, 8'h00, 1, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
